// File: rtl/aes_128_inv_core_if.sv
// Bus between the block controller / round-key file and the AES-128
// inverse-cipher core.
//
// Handshake: the controller raises start with in_data; the core accepts it on
// the rising edge only when busy is low (start while busy is ignored and
// in_data is not sampled). There is no backpressure on the result: out_valid
// is a single-cycle pulse and out_data holds the plaintext until the next
// result or kill. key_idx/key_round form a combinational lookup: the key file
// returns the round key for key_idx in the same cycle.
interface aes_128_inv_core_if;
  logic         start;
  logic [127:0] in_data;
  logic [127:0] key_round;
  logic [3:0]   key_idx;
  logic         busy;
  logic         out_valid;
  logic [127:0] out_data;
  logic [2:0]   dbg_state;

  // Controller / key-file side
  modport master (
    output start, in_data, key_round,
    input  key_idx, busy, out_valid, out_data, dbg_state
  );

  // Core side
  modport slave (
    input  start, in_data, key_round,
    output key_idx, busy, out_valid, out_data, dbg_state
  );
endinterface

// File: rtl/aes_128_inv_core.sv
// Iterative AES-128 inverse cipher. One inverse round takes three cycles
// (SUB, ADD, MIX); the final round drops InvMixColumns. Fixed latency of 30
// cycles from an accepted start to the out_valid pulse. Round keys are pulled
// from the external key file through key_idx/key_round.
module aes_128_inv_core #(
  parameter int NR = 10  // only 10 (AES-128) is a legal value
) (
  input  logic               clk,
  input  logic               kill,
  aes_128_inv_core_if.slave  bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SUB      = 3'd1;
  localparam logic [2:0] ST_ADD      = 3'd2;
  localparam logic [2:0] ST_MIX      = 3'd3;
  localparam logic [2:0] ST_LAST_SUB = 3'd4;
  localparam logic [2:0] ST_LAST_ADD = 3'd5;

  localparam logic [3:0] FIRST_RND = 4'(NR - 1);
  localparam logic [3:0] LAST_KEY  = 4'(NR);

  // ---------------------------------------------------------------------
  // GF(2^8) helpers, field polynomial x^8+x^4+x^3+x+1 (0x11B)
  // ---------------------------------------------------------------------
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] b;
    r = 8'h01;
    b = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, b);
      b = gf_mul(b, b);
    end
    return r;
  endfunction

  // Inverse S-box entry: inverse affine transform followed by field inverse.
  function automatic logic [7:0] inv_sbox_calc(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    for (int i = 0; i < 8; i++)
      y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
    return gf_inv(y ^ 8'h05);
  endfunction

  // Byte k of a block is bits [127-8k -: 8]; byte k sits at row k%4,
  // column k/4. Row r is rotated right by r positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
    return o;
  endfunction

  // Column transform with coefficient row {0e, 0b, 0d, 09}.
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m2 [4];
    logic [7:0]   m4 [4];
    logic [7:0]   m8 [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127 - 8*(4*c + r) -: 8];
        m2[r] = gf_xtime(a[r]);
        m4[r] = gf_xtime(m2[r]);
        m8[r] = gf_xtime(m4[r]);
        m9[r] = m8[r] ^ a[r];
        mb[r] = m8[r] ^ m2[r] ^ a[r];
        md[r] = m8[r] ^ m4[r] ^ a[r];
        me[r] = m8[r] ^ m4[r] ^ m2[r];
      end
      o[127 - 8*(4*c + 0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[127 - 8*(4*c + 1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[127 - 8*(4*c + 2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[127 - 8*(4*c + 3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [2:0]   fsm;
  logic [3:0]   rnd;
  logic [127:0] state;
  logic [127:0] sub_reg;
  logic [127:0] add_reg;
  logic [127:0] out_data_q;
  logic         out_valid_q;

  // Inverse S-box ROM contents; the read is registered by sub_reg, so the
  // 16 lookups map onto 16 synchronous 256x8 ROMs.
  logic [7:0] inv_sbox_rom [256];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    assign inv_sbox_rom[g] = inv_sbox_calc(8'(g));
  end

  logic [127:0] isr_state;
  logic [127:0] sub_next;

  // Address the 16 ROMs with the inverse-shifted state bytes
  always_comb begin
    isr_state = inv_shift_rows(state);
    sub_next  = '0;
    for (int k = 0; k < 16; k++)
      sub_next[127 - 8*k -: 8] = inv_sbox_rom[isr_state[127 - 8*k -: 8]];
  end

  // Round sequencer and datapath registers; kill aborts without output
  always_ff @(posedge clk) begin
    if (kill) begin
      fsm         <= ST_IDLE;
      rnd         <= 4'd0;
      state       <= '0;
      sub_reg     <= '0;
      add_reg     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (bus.start) begin
            state <= bus.in_data ^ bus.key_round;
            rnd   <= FIRST_RND;
            fsm   <= ST_SUB;
          end
        end
        ST_SUB: begin
          sub_reg <= sub_next;
          fsm     <= ST_ADD;
        end
        ST_ADD: begin
          add_reg <= sub_reg ^ bus.key_round;
          fsm     <= ST_MIX;
        end
        ST_MIX: begin
          state <= inv_mix_columns(add_reg);
          if (rnd == 4'd1) begin
            fsm <= ST_LAST_SUB;
          end else begin
            rnd <= rnd - 4'd1;
            fsm <= ST_SUB;
          end
        end
        ST_LAST_SUB: begin
          sub_reg <= sub_next;
          fsm     <= ST_LAST_ADD;
        end
        ST_LAST_ADD: begin
          out_data_q  <= sub_reg ^ bus.key_round;
          out_valid_q <= 1'b1;
          fsm         <= ST_IDLE;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  // Round-key request: rk10 while idle, rk[rnd] in ADD, rk0 in LAST_ADD
  always_comb begin
    bus.key_idx = LAST_KEY;
    case (fsm)
      ST_ADD:      bus.key_idx = rnd;
      ST_LAST_ADD: bus.key_idx = 4'd0;
      default:     bus.key_idx = LAST_KEY;
    endcase
  end

  assign bus.busy      = (fsm != ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.dbg_state = fsm;

endmodule

// File: tb/tb_aes_128_inv_core.sv
// Directed bench for the AES-128 inverse core using the FIPS-197 C.1 and
// Appendix B vectors. The bench models the round-key file itself.
module tb_aes_128_inv_core;

  typedef logic [10:0][127:0] rk_set_t;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  // ---------------- clock / reset ----------------
  logic clk;
  logic kill;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  aes_128_inv_core_if bus ();

  aes_128_inv_core #(.NR(10)) dut (
    .clk  (clk),
    .kill (kill),
    .bus  (bus)
  );

  // ---------------- key file model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Forward S-box: affine transform of the field inverse (x^254).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    logic [7:0] y;
    inv = 8'h01;
    sq  = mul(x, x);
    for (int i = 1; i < 8; i++) begin
      inv = mul(inv, sq);
      sq  = mul(sq, sq);
    end
    y = 8'h00;
    for (int i = 0; i < 8; i++)
      y[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
    return y ^ 8'h63;
  endfunction

  function automatic rk_set_t expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rk_set_t     rk;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  rk_set_t rk_a;
  rk_set_t rk_b;
  logic    key_sel;

  always_comb begin
    bus.key_round = '0;
    if (bus.key_idx <= 4'd10)
      bus.key_round = key_sel ? rk_b[bus.key_idx] : rk_a[bus.key_idx];
  end

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  int           cyc_q[$];
  int           n_checks;
  int           n_fail;
  logic         prev_valid;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected result
  always @(negedge clk) begin
    if (bus.out_valid) begin
      n_checks++;
      if (prev_valid) begin
        n_fail++;
        $display("FAIL out_valid_width: high in consecutive cycles at cycle %0d, required one-cycle pulse", cyc);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got out_data %h at cycle %0d, required no output", bus.out_data, cyc);
      end else begin
        logic [127:0] e;
        int           c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        if (bus.out_data !== e || cyc != c) begin
          n_fail++;
          $display("FAIL result: got %h at cycle %0d, required %h at cycle %0d", bus.out_data, cyc, e, c);
        end
      end
    end
    prev_valid = bus.out_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at the negedge of T0; returns at the negedge of T1.
  task automatic issue_accepted(input logic [127:0] ct, input logic [127:0] pt, input logic sel);
    key_sel     = sel;
    bus.start   = 1'b1;
    bus.in_data = ct;
    exp_q.push_back(pt);
    cyc_q.push_back(cyc + 30);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.in_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic issue_ignored(input logic [127:0] ct);
    bus.start   = 1'b1;
    bus.in_data = ct;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.in_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_result();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("result_timeout_pending", 128'(exp_q.size()), 128'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt;
    int stable_cnt;
    cyc         = 0;
    n_checks    = 0;
    n_fail      = 0;
    prev_valid  = 1'b0;
    key_sel     = 1'b0;
    kill        = 1'b1;
    bus.start   = 1'b0;
    bus.in_data = '0;
    rk_a = expand_key(KEY_A);
    rk_b = expand_key(KEY_B);

    wait_cycles(3);
    kill = 1'b0;
    wait_cycles(1);

    // Reset state
    check("reset_busy",      128'(bus.busy),      128'd0);
    check("reset_out_valid", 128'(bus.out_valid), 128'd0);
    check("reset_out_data",  bus.out_data,        128'd0);
    check("reset_key_idx",   128'(bus.key_idx),   128'd10);

    // Vector A with busy window and key_idx sequence
    issue_accepted(CT_A, PT_A, 1'b0);
    busy_cnt = 0;
    for (int t = 1; t < 30; t++) begin
      if (bus.busy) busy_cnt++;
      if (t >= 2 && t <= 26 && (t - 2) % 3 == 0)
        check("key_idx_add", 128'(bus.key_idx), 128'(9 - (t - 2) / 3));
      if (t == 29)
        check("key_idx_last_add", 128'(bus.key_idx), 128'd0);
      @(negedge clk);
    end
    check("busy_cycles_t1_t29", 128'(busy_cnt), 128'd29);
    check("busy_low_t30",       128'(bus.busy), 128'd0);

    // Back-to-back: vector B issued in T30 of vector A
    issue_accepted(CT_B, PT_B, 1'b1);
    wait_result();
    stable_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_data === PT_B && !bus.out_valid) stable_cnt++;
      @(negedge clk);
    end
    check("out_data_held", 128'(stable_cnt), 128'd10);

    // Start while busy: pulses at T5 and T29 must be ignored
    issue_accepted(CT_A, PT_A, 1'b0);
    wait_cycles(4);
    issue_ignored(CT_B);
    wait_cycles(23);
    issue_ignored(CT_B);
    wait_result();
    wait_cycles(40);
    check("out_data_after_ignored_starts", bus.out_data, PT_A);

    // Kill at T15 aborts with no output
    issue_accepted(CT_B, PT_B, 1'b1);
    wait_cycles(14);
    kill = 1'b1;
    exp_q.delete();
    cyc_q.delete();
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy",      128'(bus.busy),      128'd0);
    check("kill_out_valid", 128'(bus.out_valid), 128'd0);
    check("kill_out_data",  bus.out_data,        128'd0);
    wait_cycles(40);

    // Fresh start after kill
    issue_accepted(CT_A, PT_A, 1'b0);
    wait_result();
    wait_cycles(2);

    // kill and start at the same edge: start ignored
    kill        = 1'b1;
    bus.start   = 1'b1;
    bus.in_data = CT_A;
    @(negedge clk);
    kill      = 1'b0;
    bus.start = 1'b0;
    check("kill_start_busy",     128'(bus.busy), 128'd0);
    check("kill_start_out_data", bus.out_data,   128'd0);
    wait_cycles(35);
    check("kill_start_no_result", bus.out_data, 128'd0);

    check("pending_results_at_end", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_128_inv_core.md
Name: aes_128_inv_core

Overview:
- Iterative AES-128 inverse-cipher (decryption) datapath with its own round sequencer.
- Mirror of the encryption round core; 3-cycle inverse round, inverse S-box in registered ROM/BRAM.
- Pulls round keys from the key-expansion register file by index: key_idx out, key_round back combinationally.
- Sits beside the encryption core; fed by the block controller, result consumed by the output stage.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) supported; other values are illegal.

Ports:
- clk  in  1  clock; all logic on rising edge
- kill  in  1  synchronous active-high reset
- start  in  1  load in_data and begin decryption; sampled only when busy=0
- in_data  in  128  ciphertext block, byte 0 = bits [127:120]; sampled with accepted start
- key_round  in  128  round key selected by key_idx; valid in the same cycle, combinational
- key_idx  out  4  round-key index requested, 10..0
- busy  out  1  decryption in progress; start ignored while high
- out_valid  out  1  one-cycle pulse: out_data holds a new plaintext
- out_data  out  128  plaintext; held until the next result or kill

Behaviour:
- Reset (kill=1 at edge):
  - FSM -> IDLE; state, sub_reg, add_reg, out_data all 0; round counter 0.
  - busy=0, out_valid=0.
  - kill overrides start and aborts any operation mid-round; no partial result is ever emitted.
- FSM states: IDLE, SUB, ADD, MIX, LAST_SUB, LAST_ADD.
- key_idx is combinational from state: 10 in IDLE; rnd in ADD; 0 in LAST_ADD; 10 otherwise (don't-care for the key file).
- Cycle T0, IDLE with start=1:
  - state <= in_data ^ key_round (rk10); rnd <= 9; -> SUB.
- SUB:
  - sub_reg <= InvSubBytes(InvShiftRows(state)).
  - Inverse S-box is 16 parallel 256x8 ROMs with 1-cycle registered read.
  - -> ADD.
- ADD:
  - add_reg <= sub_reg ^ key_round (rk[rnd]); -> MIX.
- MIX:
  - state <= InvMixColumns(add_reg), GF(2^8) poly 0x11B, coefficients {0e,0b,0d,09}.
  - If rnd==1 -> LAST_SUB; else rnd <= rnd-1 -> SUB.
- LAST_SUB:
  - sub_reg <= InvSubBytes(InvShiftRows(state)); -> LAST_ADD.
- LAST_ADD:
  - out_data <= sub_reg ^ key_round (rk0); out_valid <= 1; -> IDLE.
- Timing:
  - Rounds 9..1 occupy T1..T27; LAST_SUB at T28; LAST_ADD at T29.
  - out_valid high and out_data valid in cycle T30. Fixed latency: 30 cycles from accepted start.
- busy = (FSM != IDLE): high T1..T29, low at T30.
  - start at T30 is accepted, so back-to-back throughput is one block per 30 cycles.
- start while busy: ignored; in_data not sampled; no effect on the current operation.
- out_valid is a registered single-cycle pulse; it is 0 in every cycle except the one following LAST_ADD.
- The enable into InvMixColumns is internal (MIX state only). There is no external mix enable.

Test Plan:
- FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f (key file holds expanded rk0..rk10), start with in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_valid at T30 with out_data 00112233445566778899aabbccddeeff; busy=1 over T1..T29.
- FIPS-197 App. B vector: key 2b7e151628aed2a6abf7158809cf4f3c, in_data 3925841d02dc09fbdc118597196a0b32 -> out_data 3243f6a8885a308d313198a2e0370734 at T30; out_data stays stable afterwards until the next result.
- key_idx sequence: sample key_idx in T0 and in each ADD/LAST_ADD cycle -> 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, exactly once each.
- Back-to-back: start at T0 with vector A, then start at T30 with vector B -> both accepted; plaintext A at T30, plaintext B at T60; each out_valid is exactly 1 cycle.
- Start while busy: extra start pulses at T5 and T29 with a different in_data -> ignored; T30 result equals the first block's plaintext; no second out_valid.
- Kill mid-operation: kill at T15 -> next cycle busy=0, out_valid=0, out_data=0; no out_valid ever follows. A fresh start after kill yields the correct result 30 cycles later. kill and start together at the same edge -> start ignored.
